// File: rtl/ysyx_041461_pc_gen_pkg.sv
// Shared constants and types for the IF-stage PC generator: mtvec modes,
// redirect priority classes, reset PC default and the sequencing FSM states.
package ysyx_041461_pc_gen_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Lower class value means higher priority; redirect channel i is class 2+i.
    localparam int CLS_W = 3;
    typedef logic [CLS_W-1:0] prio_cls_t;
    localparam prio_cls_t CLS_TRAP       = 3'd0;
    localparam prio_cls_t CLS_MRET       = 3'd1;
    localparam prio_cls_t CLS_REDIR_BASE = 3'd2;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    // A newcomer may overwrite the pending slot when it is at least as urgent.
    function automatic logic cls_may_replace(input prio_cls_t new_cls, input prio_cls_t old_cls);
        return (new_cls <= old_cls);
    endfunction

endpackage

// File: rtl/ysyx_041461_pc_gen_if.sv
// Fetch-side handshake between the PC generator (master) and the fetch unit (slave).
interface ysyx_041461_pc_gen_if #(
    parameter int XLEN = 64
);
    logic            pc_valid;
    logic            pc_ready;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            misalign_err;

    modport master (
        output pc_valid,
        output pc,
        output flush,
        output misalign_err,
        input  pc_ready
    );

    modport slave (
        input  pc_valid,
        input  pc,
        input  flush,
        input  misalign_err,
        output pc_ready
    );
endinterface

// File: rtl/ysyx_041461_pc_redir_arb.sv
// Combinational arbiter: picks the most urgent of trap, mret and redirect
// channels, forms the trap target from mtvec and aligns the chosen target.
module ysyx_041461_pc_redir_arb
    import ysyx_041461_pc_gen_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NUM_REDIR = 2,
    parameter int C_EXT     = 0
) (
    input  logic                      trap_req,
    input  logic                      mret_req,
    input  logic [XLEN-1:0]           mtvec,
    input  logic [XLEN-1:0]           mepc,
    input  logic [XLEN-2:0]           cause,
    input  logic                      cause_irq,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    output logic                      win_valid,
    output prio_cls_t                 win_cls,
    output logic [XLEN-1:0]           win_target,
    output logic                      win_misalign
);

    localparam logic [XLEN-1:0] LOW_MASK = (C_EXT != 0) ? {{(XLEN-2){1'b0}}, 2'b01}
                                                        : {{(XLEN-2){1'b0}}, 2'b11};

    logic [XLEN-1:0] trap_base_s;
    logic [XLEN-1:0] trap_tgt_s;
    logic            rd_valid_s;
    prio_cls_t       rd_cls_s;
    logic [XLEN-1:0] rd_tgt_s;
    logic [XLEN-1:0] raw_s;

    // Trap target: vectored mode offsets interrupts by cause*4, wrapping at XLEN.
    always_comb begin
        trap_base_s = {mtvec[XLEN-1:2], 2'b00};
        if ((mtvec[1:0] == MTVEC_VECTORED) && cause_irq) begin
            trap_tgt_s = trap_base_s + XLEN'({cause, 2'b00});
        end else begin
            trap_tgt_s = trap_base_s;
        end
    end

    // Redirect channels: scan from the lowest priority so channel 0 lands last.
    always_comb begin
        rd_valid_s = 1'b0;
        rd_cls_s   = CLS_REDIR_BASE;
        rd_tgt_s   = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            rd_valid_s = redir_valid[i] ? 1'b1 : rd_valid_s;
            rd_cls_s   = redir_valid[i] ? (CLS_REDIR_BASE + prio_cls_t'(i)) : rd_cls_s;
            rd_tgt_s   = redir_valid[i] ? redir_target[i*XLEN +: XLEN] : rd_tgt_s;
        end
    end

    // Final priority: trap over mret over any redirect channel.
    always_comb begin
        win_valid = 1'b0;
        win_cls   = CLS_REDIR_BASE;
        raw_s     = '0;
        if (trap_req) begin
            win_valid = 1'b1;
            win_cls   = CLS_TRAP;
            raw_s     = trap_tgt_s;
        end else if (mret_req) begin
            win_valid = 1'b1;
            win_cls   = CLS_MRET;
            raw_s     = mepc;
        end else begin
            win_valid = rd_valid_s;
            win_cls   = rd_cls_s;
            raw_s     = rd_tgt_s;
        end
    end

    // Trap targets are already word aligned, so masking them is harmless.
    assign win_target   = raw_s & ~LOW_MASK;
    assign win_misalign = |(raw_s & LOW_MASK);

endmodule

// File: rtl/ysyx_041461_pc_gen.sv
// IF-stage PC generator: boot/run sequencing, architectural fetch PC and a
// single pending-redirect slot that absorbs events arriving during stalls.
module ysyx_041461_pc_gen
    import ysyx_041461_pc_gen_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          NUM_REDIR = 2,
    parameter int          C_EXT     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    ysyx_041461_pc_gen_if.master      fetch,
    input  logic                      trap_req,
    input  logic                      mret_req,
    input  logic [XLEN-1:0]           mtvec,
    input  logic [XLEN-1:0]           mepc,
    input  logic [XLEN-2:0]           cause,
    input  logic                      cause_irq,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target
);

    localparam logic [XLEN-1:0] RESET_PC_X = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    pc_state_e       state_r,       state_s;
    logic [XLEN-1:0] pc_r,          pc_s;
    logic            pc_valid_r,    pc_valid_s;
    logic            flush_r,       flush_s;
    logic            misalign_r,    misalign_s;
    logic            pend_valid_r,  pend_valid_s;
    prio_cls_t       pend_cls_r,    pend_cls_s;
    logic [XLEN-1:0] pend_tgt_r,    pend_tgt_s;
    logic            pend_mis_r,    pend_mis_s;

    logic            win_valid_s;
    prio_cls_t       win_cls_s;
    logic [XLEN-1:0] win_tgt_s;
    logic            win_mis_s;
    logic            fire_s;
    logic            capture_s;

    ysyx_041461_pc_redir_arb #(
        .XLEN      (XLEN),
        .NUM_REDIR (NUM_REDIR),
        .C_EXT     (C_EXT)
    ) u_arb (
        .trap_req     (trap_req),
        .mret_req     (mret_req),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .cause        (cause),
        .cause_irq    (cause_irq),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .win_valid    (win_valid_s),
        .win_cls      (win_cls_s),
        .win_target   (win_tgt_s),
        .win_misalign (win_mis_s)
    );

    assign fire_s    = pc_valid_r & fetch.pc_ready & ~stall;
    assign capture_s = win_valid_s & (~pend_valid_r | cls_may_replace(win_cls_s, pend_cls_r));

    // Next-state, PC and pending-slot decisions.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        pc_valid_s   = pc_valid_r;
        flush_s      = 1'b0;
        misalign_s   = 1'b0;
        pend_valid_s = pend_valid_r;
        pend_cls_s   = pend_cls_r;
        pend_tgt_s   = pend_tgt_r;
        pend_mis_s   = pend_mis_r;
        case (state_r)
            ST_BOOT: begin
                state_s    = ST_RUN;
                pc_valid_s = 1'b1;
                if (capture_s) begin
                    pend_valid_s = 1'b1;
                    pend_cls_s   = win_cls_s;
                    pend_tgt_s   = win_tgt_s;
                    pend_mis_s   = win_mis_s;
                end else begin
                    pend_valid_s = pend_valid_r;
                end
            end
            ST_RUN: begin
                pc_valid_s = 1'b1;
                if (stall) begin
                    if (capture_s) begin
                        pend_valid_s = 1'b1;
                        pend_cls_s   = win_cls_s;
                        pend_tgt_s   = win_tgt_s;
                        pend_mis_s   = win_mis_s;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                end else if (win_valid_s) begin
                    // Ties go to the newcomer; the loser is dropped either way.
                    if (pend_valid_r && (pend_cls_r < win_cls_s)) begin
                        pc_s       = pend_tgt_r;
                        misalign_s = pend_mis_r;
                    end else begin
                        pc_s       = win_tgt_s;
                        misalign_s = win_mis_s;
                    end
                    pend_valid_s = 1'b0;
                    flush_s      = 1'b1;
                end else if (pend_valid_r) begin
                    pc_s         = pend_tgt_r;
                    misalign_s   = pend_mis_r;
                    pend_valid_s = 1'b0;
                    flush_s      = 1'b1;
                end else if (fire_s) begin
                    pc_s = pc_r + PC_STEP;
                end else begin
                    pc_s = pc_r;
                end
            end
            default: begin
                state_s    = ST_BOOT;
                pc_valid_s = 1'b0;
            end
        endcase
    end

    // State, PC, output pulses and pending slot; reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC_X;
            pc_valid_r   <= 1'b0;
            flush_r      <= 1'b0;
            misalign_r   <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_cls_r   <= CLS_TRAP;
            pend_tgt_r   <= '0;
            pend_mis_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pc_valid_r   <= pc_valid_s;
            flush_r      <= flush_s;
            misalign_r   <= misalign_s;
            pend_valid_r <= pend_valid_s;
            pend_cls_r   <= pend_cls_s;
            pend_tgt_r   <= pend_tgt_s;
            pend_mis_r   <= pend_mis_s;
        end
    end

    assign fetch.pc           = pc_r;
    assign fetch.pc_valid     = pc_valid_r;
    assign fetch.flush        = flush_r;
    assign fetch.misalign_err = misalign_r;

endmodule

// File: tb/tb_ysyx_041461_pc_gen.sv
// Directed bench for the PC generator: boot, handshake, traps, priority,
// stall buffering, alignment, wrap-around and reset of the pending slot.
module tb_ysyx_041461_pc_gen;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         trap_req;
    logic         mret_req;
    logic [63:0]  mtvec;
    logic [63:0]  mepc;
    logic [62:0]  cause;
    logic         cause_irq;
    logic [1:0]   redir_valid;
    logic [127:0] redir_target;

    int n_checks;
    int n_fail;

    ysyx_041461_pc_gen_if #(.XLEN(64)) fif ();

    ysyx_041461_pc_gen #(
        .XLEN      (64),
        .RESET_PC  (64'h0000_0000_8000_0000),
        .NUM_REDIR (2),
        .C_EXT     (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .fetch        (fif.master),
        .trap_req     (trap_req),
        .mret_req     (mret_req),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .cause        (cause),
        .cause_irq    (cause_irq),
        .redir_valid  (redir_valid),
        .redir_target (redir_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fif.pc_ready = 1'b1;
        n_checks++; if (fif.pc !== 64'h8000_0000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", fif.pc, 64'h8000_0000); end
        n_checks++; if (fif.pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", fif.pc_valid); end
        n_checks++; if (fif.flush !== 1'b0 || fif.misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b exp 00", fif.flush, fif.misalign_err); end
        step();
        n_checks++; if (fif.pc_valid !== 1'b1 || fif.pc !== 64'h8000_0000) begin n_fail++; $display("FAIL boot_run got %b %h exp 1 80000000", fif.pc_valid, fif.pc); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0004) begin n_fail++; $display("FAIL seq1 got %h exp 80000004", fif.pc); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0008) begin n_fail++; $display("FAIL seq2 got %h exp 80000008", fif.pc); end
    endtask

    task automatic test_ready_hold();
        fif.pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (fif.pc !== 64'h8000_0008 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL hold%0d got %h/%b exp 80000008/0", i, fif.pc, fif.flush); end
        end
        fif.pc_ready = 1'b1;
        step();
        fif.pc_ready = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_000C) begin n_fail++; $display("FAIL resume got %h exp 8000000c", fif.pc); end
    endtask

    task automatic test_trap();
        trap_req = 1'b1; mtvec = 64'h8000_1001; cause_irq = 1'b1; cause = 63'd7;
        step();
        trap_req = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_101C || fif.flush !== 1'b1) begin n_fail++; $display("FAIL trap_vec got %h/%b exp 8000101c/1", fif.pc, fif.flush); end
        n_checks++; if (fif.misalign_err !== 1'b0) begin n_fail++; $display("FAIL trap_mis got %b exp 0", fif.misalign_err); end
        step();
        n_checks++; if (fif.flush !== 1'b0 || fif.pc !== 64'h8000_101C) begin n_fail++; $display("FAIL trap_after got %h/%b exp 8000101c/0", fif.pc, fif.flush); end
        trap_req = 1'b1; cause_irq = 1'b0;
        step();
        trap_req = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_1000 || fif.flush !== 1'b1) begin n_fail++; $display("FAIL trap_exc got %h/%b exp 80001000/1", fif.pc, fif.flush); end
    endtask

    task automatic test_simultaneous();
        trap_req = 1'b1; mret_req = 1'b1; mtvec = 64'h8000_2000; cause_irq = 1'b0;
        mepc = 64'h8000_0100; redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0200;
        step();
        trap_req = 1'b0; mret_req = 1'b0; redir_valid = 2'b00;
        n_checks++; if (fif.pc !== 64'h8000_2000 || fif.flush !== 1'b1) begin n_fail++; $display("FAIL simul got %h/%b exp 80002000/1", fif.pc, fif.flush); end
        step();
        step();
        n_checks++; if (fif.pc !== 64'h8000_2000 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL simul_drop got %h/%b exp 80002000/0", fif.pc, fif.flush); end
    endtask

    task automatic test_stall_pending();
        stall = 1'b1; redir_valid = 2'b10; redir_target[127:64] = 64'h8000_0300;
        step();
        n_checks++; if (fif.pc !== 64'h8000_2000 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL stall_hold got %h/%b exp 80002000/0", fif.pc, fif.flush); end
        redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0400;
        step();
        stall = 1'b0; redir_valid = 2'b00;
        n_checks++; if (fif.pc !== 64'h8000_2000) begin n_fail++; $display("FAIL stall_hold2 got %h exp 80002000", fif.pc); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0400 || fif.flush !== 1'b1) begin n_fail++; $display("FAIL pend_apply got %h/%b exp 80000400/1", fif.pc, fif.flush); end
        step();
        n_checks++; if (fif.flush !== 1'b0) begin n_fail++; $display("FAIL pend_single got %b exp 0", fif.flush); end
        fif.pc_ready = 1'b1;
        step();
        fif.pc_ready = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_0404) begin n_fail++; $display("FAIL pend_adv got %h exp 80000404", fif.pc); end
        stall = 1'b1; redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0400;
        step();
        redir_valid = 2'b10; redir_target[127:64] = 64'h8000_0300;
        step();
        stall = 1'b0; redir_valid = 2'b00;
        step();
        n_checks++; if (fif.pc !== 64'h8000_0400 || fif.flush !== 1'b1) begin n_fail++; $display("FAIL pend_rev got %h/%b exp 80000400/1", fif.pc, fif.flush); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0400 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL pend_rev_drop got %h/%b exp 80000400/0", fif.pc, fif.flush); end
    endtask

    task automatic test_align_wrap();
        redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0006;
        step();
        redir_valid = 2'b00;
        n_checks++; if (fif.pc !== 64'h8000_0004 || fif.misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign got %h/%b exp 80000004/1", fif.pc, fif.misalign_err); end
        step();
        n_checks++; if (fif.misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse got %b exp 0", fif.misalign_err); end
        mret_req = 1'b1; mepc = 64'h8000_0102;
        step();
        mret_req = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_0100 || fif.misalign_err !== 1'b1) begin n_fail++; $display("FAIL mret_align got %h/%b exp 80000100/1", fif.pc, fif.misalign_err); end
        redir_valid = 2'b01; redir_target[63:0] = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redir_valid = 2'b00;
        n_checks++; if (fif.pc !== 64'hFFFF_FFFF_FFFF_FFFC || fif.misalign_err !== 1'b0) begin n_fail++; $display("FAIL wrap_pre got %h/%b exp fffffffffffffffc/0", fif.pc, fif.misalign_err); end
        fif.pc_ready = 1'b1;
        step();
        fif.pc_ready = 1'b0;
        n_checks++; if (fif.pc !== 64'h0 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL wrap got %h/%b exp 0/0", fif.pc, fif.flush); end
    endtask

    task automatic test_reset_pending();
        stall = 1'b1; redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0500;
        step();
        redir_valid = 2'b00; rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        n_checks++; if (fif.pc !== 64'h8000_0000 || fif.pc_valid !== 1'b0 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %h/%b/%b exp 80000000/0/0", fif.pc, fif.pc_valid, fif.flush); end
        step();
        n_checks++; if (fif.pc_valid !== 1'b1 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL rst_boot got %b/%b exp 1/0", fif.pc_valid, fif.flush); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0000 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL rst_discard got %h/%b exp 80000000/0", fif.pc, fif.flush); end
    endtask

    task automatic test_boot_capture();
        rst = 1'b1;
        step();
        rst = 1'b0; redir_valid = 2'b01; redir_target[63:0] = 64'h8000_0600;
        step();
        redir_valid = 2'b00;
        n_checks++; if (fif.pc !== 64'h8000_0000 || fif.flush !== 1'b0) begin n_fail++; $display("FAIL boot_cap got %h/%b exp 80000000/0", fif.pc, fif.flush); end
        step();
        n_checks++; if (fif.pc !== 64'h8000_0600 || fif.flush !== 1'b1) begin n_fail++; $display("FAIL boot_apply got %h/%b exp 80000600/1", fif.pc, fif.flush); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; stall = 1'b0; trap_req = 1'b0; mret_req = 1'b0;
        mtvec = 64'h0; mepc = 64'h0; cause = 63'h0; cause_irq = 1'b0;
        redir_valid = 2'b00; redir_target = 128'h0; fif.pc_ready = 1'b0;
        test_reset();
        test_ready_hold();
        test_trap();
        test_simultaneous();
        test_stall_pending();
        test_align_wrap();
        test_reset_pending();
        test_boot_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
